dpi_stream_xform: RTL and testbench
===================================

Name: dpi_stream_xform

Overview:
- Parametrised successor to the single-lane DPI drive/increment/monitor loop: CH independent channels, each with a valid/ready input, a per-beat transform and an output FIFO of DEPTH entries.
- DPI-C driver and monitor shims in the sim top feed and drain each channel every v_clk.
- Adds back-pressure, selectable transform mode, end-of-stream tracking and beat counters, so the C side can detect completion per channel without polling data values.

Parameters:
- CH, 4, number of independent channels (1..16).
- W, 32, data width per channel in bits.
- DEPTH, 4, output FIFO entries per channel (power of two, 2..64).
- INCR, 1, constant used by add/sub modes; truncated to W bits.

Ports:
- v_clk  input  1  clock; all logic on posedge.
- v_rst  input  1  synchronous active-high reset.
- mode  input  2  transform: 0 pass, 1 add INCR, 2 sub INCR, 3 bitwise invert.
- in_valid  input  CH  per-channel beat offered.
- in_ready  output  CH  per-channel beat accepted when valid&ready.
- in_data  input  CH*W  channel c at bits [c*W +: W].
- in_last  input  CH  final beat of channel stream.
- out_valid  output  CH  FIFO head valid.
- out_ready  input  CH  consumer pops head when valid&ready.
- out_data  output  CH*W  transformed head data, same packing as in_data.
- out_last  output  CH  head beat carries last.
- beats_in  output  CH*32  accepted-beat counter per channel.
- beats_out  output  CH*32  popped-beat counter per channel.
- done  output  CH  sticky: last beat of channel popped.
- all_done  output  1  AND of done.

Behaviour:
- Reset, sampled on posedge when v_rst=1: FIFO pointers and counts cleared, in-flight data discarded, beats_in/beats_out=0, done=0, all_done=0.
- Outputs during reset: out_valid=0 and in_ready=0 (in_ready is gated by v_rst). in_ready rises the cycle after v_rst deasserts.
- Reset mid-stream drops all buffered beats; no partial pops.
- Channels are fully independent. Back-pressure on one channel never affects another.
- Per-channel occupancy count 0..DEPTH.
- in_ready[c] = !v_rst && (count != DEPTH). Decided from count only, so a pop in the same cycle does not raise in_ready when full (no combinational ready->ready path).
- Accept: in_valid&in_ready. Transform is applied combinationally using mode sampled in the accept cycle. Result and in_last are written to the FIFO tail at that edge.
- Accept latency: out_valid earliest on the cycle after accept. There is no bypass, so latency is exactly 1 when the FIFO was empty.
- Pop: out_valid&out_ready advances head. out_data/out_last reflect the head entry combinationally from FIFO storage.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged.
- Simultaneous push and pop at count=0: the push lands and the pop is impossible (out_valid=0).
- Arithmetic is modulo 2^W: add wraps 2^W-1 -> INCR-1; sub wraps 0 -> 2^W-INCR.
- Pointers wrap modulo DEPTH.
- beats_in[c] +1 per accept; beats_out[c] +1 per pop. Both 32-bit, wrap silently.
- done[c] sets on the edge where a beat with last=1 is popped. It stays set until reset.
- Beats accepted after done are still processed and counted; done stays 1.
- mode changes only affect beats accepted afterwards; already-buffered beats keep their transform.
- Holding in_valid with no ready is legal; data must stay stable until accepted (source obligation, asserted in the bench).

Test Plan:
- Reset/idle: v_rst high 3 cycles -> out_valid=0, in_ready=0, counters 0. After deassert, in_ready=all 1s next cycle.
- Single beat, CH0, mode=1, INCR=1, data 0x0000_0041, out_ready=1 -> out_valid cycle+1 with 0x0000_0042; beats_in=beats_out=1.
- Wrap and modes, W=32: 0xFFFF_FFFF mode1 -> 0x0000_0000; 0x0 mode2 -> 0xFFFF_FFFF; 0x0F0F_0F0F mode3 -> 0xF0F0_F0F0; 0x1234 mode0 -> 0x1234.
- Back-pressure, DEPTH=4: CH1 out_ready=0, 6 beats offered -> 4 accepted, in_ready[1]=0. Then out_ready=1 with in_valid held -> in_ready rises the cycle after the first pop; all 6 beats delivered in order; other channels unaffected.
- Completion: each channel sends 10 beats, last on the 10th, random out_ready -> done[c] sets on the 10th pop; all_done when the final channel finishes; beats_out=10 each.
- Reset mid-stream: 3 beats buffered in CH2, pulse v_rst -> out_valid[2]=0 next cycle, counters 0, no stale beat ever emerges.

Source files
------------

// File: rtl/dpi_stream_xform.sv
// rtl/dpi_stream_xform.sv - multi-channel valid/ready transform with per-channel output FIFO and completion tracking
module dpi_stream_xform #(
  parameter int CH    = 4,
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int INCR  = 1
) (
  input  logic            v_clk,
  input  logic            v_rst,
  input  logic [1:0]      mode,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_last,
  output logic [CH-1:0]   out_valid,
  input  logic [CH-1:0]   out_ready,
  output logic [CH*W-1:0] out_data,
  output logic [CH-1:0]   out_last,
  output logic [CH*32-1:0] beats_in,
  output logic [CH*32-1:0] beats_out,
  output logic [CH-1:0]   done,
  output logic            all_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [W-1:0]  INCR_W = W'(INCR);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0]  din;
    logic [W-1:0]  xf;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   bin_q, bin_d, bout_q, bout_d;
    logic          done_q, done_d;
    // bit W holds the beat's last flag alongside its transformed data
    logic [W:0]    mem_q [DEPTH];

    assign din = in_data[c*W +: W];

    always_comb begin
      xf = din;
      case (mode)
        2'd1:    xf = din + INCR_W;
        2'd2:    xf = din - INCR_W;
        2'd3:    xf = ~din;
        default: xf = din;
      endcase
    end

    // ready depends only on occupancy so a same-cycle pop never feeds back into it
    assign in_ready[c]  = !v_rst && (count_q != FULL);
    assign out_valid[c] = !v_rst && (count_q != '0);
    assign push         = in_valid[c] && in_ready[c];
    assign pop          = out_valid[c] && out_ready[c];

    always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      bin_d   = bin_q;
      bout_d  = bout_q;
      done_d  = done_q;
      if (push) begin
        tail_d = tail_q + ONE_P;
        bin_d  = bin_q + 32'd1;
      end
      if (pop) begin
        head_d = head_q + ONE_P;
        bout_d = bout_q + 32'd1;
        done_d = done_q | mem_q[head_q][W];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge v_clk) begin
      if (v_rst) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        bin_q   <= '0;
        bout_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        bin_q   <= bin_d;
        bout_q  <= bout_d;
        done_q  <= done_d;
      end
    end

    always_ff @(posedge v_clk) begin
      if (push) begin
        mem_q[tail_q] <= {in_last[c], xf};
      end
    end

    assign out_data[c*W +: W]    = mem_q[head_q][W-1:0];
    assign out_last[c]           = mem_q[head_q][W];
    assign beats_in[c*32 +: 32]  = bin_q;
    assign beats_out[c*32 +: 32] = bout_q;
    assign done[c]               = done_q;
  end

  assign all_done = &done;

endmodule

// File: tb/tb_dpi_stream_xform.sv
// tb/tb_dpi_stream_xform.sv - directed bench with queue-based reference model for dpi_stream_xform
module tb_dpi_stream_xform;
  localparam int CH    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int INCR  = 1;

  logic            v_clk = 1'b0;
  logic            v_rst = 1'b1;
  logic [1:0]      mode = 2'd0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   in_last = '0;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready = '0;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_last;
  logic [CH*32-1:0] beats_in;
  logic [CH*32-1:0] beats_out;
  logic [CH-1:0]   done;
  logic            all_done;

  int checks = 0;
  int errors = 0;

  dpi_stream_xform #(.CH(CH), .W(W), .DEPTH(DEPTH), .INCR(INCR)) dut (
    .v_clk(v_clk), .v_rst(v_rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .beats_in(beats_in), .beats_out(beats_out), .done(done), .all_done(all_done)
  );

  always #5 v_clk = ~v_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] xf(input logic [W-1:0] d, input logic [1:0] m);
    case (m)
      2'd1:    return d + W'(INCR);
      2'd2:    return d - W'(INCR);
      2'd3:    return ~d;
      default: return d;
    endcase
  endfunction

  // sources: per-channel beat queues; sinks: 0 stall, 1 always ready, 2 random
  logic [W:0]  src_q [CH][$];
  logic [1:0]  sink [CH];
  logic [CH-1:0] acc_s = '0;

  always @(negedge v_clk) acc_s = in_valid & in_ready;

  always @(posedge v_clk) begin
    #2;
    for (int c = 0; c < CH; c++) begin
      if (acc_s[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      if (src_q[c].size() > 0) begin
        in_valid[c]         = 1'b1;
        in_data[c*W +: W]   = src_q[c][0][W-1:0];
        in_last[c]          = src_q[c][0][W];
      end else begin
        in_valid[c] = 1'b0;
      end
      out_ready[c] = (sink[c] == 2'd2) ? 1'($urandom_range(0, 1)) : sink[c][0];
    end
  end

  // reference model: FIFO contents as queues, counters as plain integers
  logic [W:0]   exp_q [CH][$];
  int unsigned  m_in [CH];
  int unsigned  m_out [CH];
  logic [CH-1:0] m_done = '0;

  always @(posedge v_clk) begin
    int sz;
    logic [W:0] e;
    if (v_rst) begin
      for (int c = 0; c < CH; c++) begin
        exp_q[c].delete();
        m_in[c]  = 0;
        m_out[c] = 0;
      end
      m_done = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        sz = exp_q[c].size();
        if (sz > 0 && out_ready[c]) begin
          e = exp_q[c].pop_front();
          m_out[c]++;
          if (e[W]) m_done[c] = 1'b1;
        end
        if (in_valid[c] && sz < DEPTH) begin
          exp_q[c].push_back({in_last[c], xf(in_data[c*W +: W], mode)});
          m_in[c]++;
        end
      end
    end
  end

  logic [CH-1:0] prev_pend = '0;
  logic [CH*W-1:0] prev_data = '0;

  always @(negedge v_clk) begin
    logic ev;
    for (int c = 0; c < CH; c++) begin
      ev = !v_rst && exp_q[c].size() > 0;
      chk($sformatf("ch%0d out_valid", c), 64'(out_valid[c]), 64'(ev));
      chk($sformatf("ch%0d in_ready", c), 64'(in_ready[c]),
          64'(!v_rst && exp_q[c].size() < DEPTH));
      if (ev && out_valid[c]) begin
        chk($sformatf("ch%0d out_data", c), 64'(out_data[c*W +: W]), 64'(exp_q[c][0][W-1:0]));
        chk($sformatf("ch%0d out_last", c), 64'(out_last[c]), 64'(exp_q[c][0][W]));
      end
      chk($sformatf("ch%0d beats_in", c), 64'(beats_in[c*32 +: 32]), 64'(m_in[c]));
      chk($sformatf("ch%0d beats_out", c), 64'(beats_out[c*32 +: 32]), 64'(m_out[c]));
      chk($sformatf("ch%0d done", c), 64'(done[c]), 64'(m_done[c]));
      if (prev_pend[c] && in_valid[c] && in_data[c*W +: W] !== prev_data[c*W +: W]) begin
        errors++;
        $display("FAIL ch%0d source stability: data %0h changed from %0h", c,
                 in_data[c*W +: W], prev_data[c*W +: W]);
      end
    end
    chk("all_done", 64'(all_done), 64'(&m_done));
    prev_pend = in_valid & ~in_ready;
    prev_data = in_data;
  end

  task automatic send_one(input int c, input logic [W-1:0] d, input logic [W-1:0] exp, input string name);
    bit seen;
    seen = 0;
    src_q[c].push_back({1'b0, d});
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge v_clk);
      if (in_valid[c] && in_ready[c]) seen = 1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s: accept timeout got none expected accept", name);
    end else begin
      chk({name, " pre"}, 64'(out_valid[c]), 64'd0);
      @(negedge v_clk);
      chk({name, " valid"}, 64'(out_valid[c]), 64'd1);
      chk({name, " data"}, 64'(out_data[c*W +: W]), 64'(exp));
    end
  endtask

  task automatic pulse_reset();
    @(posedge v_clk); #3; v_rst = 1'b1;
    @(posedge v_clk); #3; v_rst = 1'b0;
  endtask

  initial begin
    bit ok;
    for (int c = 0; c < CH; c++) sink[c] = 2'd1;

    repeat (3) @(negedge v_clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst beats_in", 64'(beats_in[63:0]), 64'd0);
    @(posedge v_clk); #3; v_rst = 1'b0;
    @(negedge v_clk);
    chk("post-rst in_ready", 64'(in_ready), 64'hF);

    mode = 2'd1;
    send_one(0, 32'h0000_0041, 32'h0000_0042, "single");
    @(negedge v_clk);
    chk("single popped", 64'(out_valid[0]), 64'd0);
    chk("single beats_in", 64'(beats_in[31:0]), 64'd1);
    chk("single beats_out", 64'(beats_out[31:0]), 64'd1);

    mode = 2'd1; send_one(0, 32'hFFFF_FFFF, 32'h0000_0000, "add wrap");
    mode = 2'd2; send_one(0, 32'h0000_0000, 32'hFFFF_FFFF, "sub wrap");
    mode = 2'd3; send_one(0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, "invert");
    mode = 2'd0; send_one(0, 32'h0000_1234, 32'h0000_1234, "pass");
    repeat (2) @(negedge v_clk);

    sink[1] = 2'd0;
    for (int i = 0; i < 6; i++) src_q[1].push_back({1'b0, 32'h100 + 32'(i)});
    for (int i = 0; i < 2; i++) begin
      src_q[0].push_back({1'b0, 32'h200 + 32'(i)});
      src_q[3].push_back({1'b0, 32'h300 + 32'(i)});
    end
    repeat (12) @(negedge v_clk);
    chk("bp ch1 beats_in", 64'(beats_in[32 +: 32]), 64'd4);
    chk("bp ch1 in_ready", 64'(in_ready[1]), 64'd0);
    chk("bp ch0 beats_out", 64'(beats_out[0 +: 32]), 64'd7);
    chk("bp ch3 beats_out", 64'(beats_out[96 +: 32]), 64'd2);
    sink[1] = 2'd1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge v_clk);
      if (beats_out[32 +: 32] == 32'd6) ok = 1;
    end
    chk("bp ch1 drained", 64'(beats_out[32 +: 32]), 64'd6);

    sink[2] = 2'd0;
    for (int i = 0; i < 3; i++) src_q[2].push_back({1'b0, 32'hA00 + 32'(i)});
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge v_clk);
      if (beats_in[64 +: 32] == 32'd3) ok = 1;
    end
    chk("mid ch2 buffered", 64'(beats_in[64 +: 32]), 64'd3);
    pulse_reset();
    @(negedge v_clk);
    chk("mid out_valid2", 64'(out_valid[2]), 64'd0);
    chk("mid beats_in", 64'(beats_in[127:64]), 64'd0);
    chk("mid beats_out", 64'(beats_out[63:0]), 64'd0);
    sink[2] = 2'd1;
    repeat (5) @(negedge v_clk);
    chk("mid no stale", 64'(out_valid[2]), 64'd0);

    mode = 2'd3;
    for (int c = 0; c < CH; c++) begin
      sink[c] = 2'd2;
      for (int i = 1; i <= 10; i++)
        src_q[c].push_back({(i == 10), 32'(c * 32'h1000 + i)});
    end
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge v_clk);
      if (all_done) ok = 1;
    end
    chk("cmp all_done", 64'(all_done), 64'd1);
    chk("cmp done", 64'(done), 64'hF);
    for (int c = 0; c < CH; c++)
      chk($sformatf("cmp ch%0d beats_out", c), 64'(beats_out[c*32 +: 32]), 64'd10);

    sink[0] = 2'd1;
    src_q[0].push_back({1'b0, 32'h5555});
    repeat (6) @(negedge v_clk);
    chk("post-done beats_out", 64'(beats_out[31:0]), 64'd11);
    chk("post-done done0", 64'(done[0]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
